// File: rtl/cisc_fetch_unit.sv
// Byte-serial fetch unit: reads four consecutive bytes per instruction, presents the
// assembled instruction with a valid/ready handshake, and supports flush and halt.
module cisc_fetch_unit #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  input  logic [7:0] mem_rdata,
  input  logic       mem_rvalid,
  input  logic       redirect,
  input  logic [7:0] redirect_pc,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] opcode,
  output logic [7:0] operand1,
  output logic [7:0] operand2,
  output logic [7:0] operand3,
  output logic [7:0] out_pc,
  output logic       halted
);

  typedef enum logic [2:0] {FETCH, WAIT, HOLD, DRAIN, HALT} state_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] addr_q, addr_d;
  logic       latch;
  logic       accept;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    latch   = 1'b0;
    accept  = (state_q == HOLD) && out_ready;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          addr_d = redirect_pc;
          idx_d  = '0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          addr_d  = redirect_pc;
          idx_d   = '0;
          state_d = mem_rvalid ? FETCH : DRAIN;
        end else if (mem_rvalid) begin
          latch  = 1'b1;
          addr_d = addr_q + 8'd1;
          idx_d  = idx_q + 2'd1;
          // opcode already holds byte 0 of this instruction when the last byte lands
          if (idx_q != 2'd3)              state_d = FETCH;
          else if (opcode == HALT_OPCODE) state_d = HALT;
          else                            state_d = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          state_d = FETCH;
        end else if (redirect) begin
          addr_d  = redirect_pc;
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (redirect) begin
          addr_d = redirect_pc;
          idx_d  = '0;
        end
        if (mem_rvalid) state_d = FETCH;
      end
      HALT: begin
        if (redirect) begin
          addr_d  = redirect_pc;
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // A redirect in FETCH suppresses the read so no stale response can follow it.
  assign mem_rd    = (state_q == FETCH) && !redirect && !rst;
  assign mem_addr  = addr_q;
  assign out_valid = (state_q == HOLD);
  assign halted    = (state_q == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      idx_q    <= '0;
      addr_q   <= RESET_PC;
      opcode   <= '0;
      operand1 <= '0;
      operand2 <= '0;
      operand3 <= '0;
      out_pc   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      if (latch) begin
        case (idx_q)
          2'd0: begin
            opcode <= mem_rdata;
            out_pc <= addr_q;
          end
          2'd1:    operand1 <= mem_rdata;
          2'd2:    operand2 <= mem_rdata;
          default: operand3 <= mem_rdata;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cisc_fetch_unit.sv
// Self-checking bench for cisc_fetch_unit: transaction-level reference model with a
// variable-latency memory, directed scenarios with literal expectations, then random traffic.
module tb_cisc_fetch_unit;

  localparam logic [7:0] HALT_OP = 8'hFF;
  localparam logic [7:0] RST_PC  = 8'h00;

  logic       clk;
  logic       rst, mem_rd, mem_rvalid, redirect, out_valid, out_ready, halted;
  logic [7:0] mem_addr, mem_rdata, redirect_pc, opcode, operand1, operand2, operand3, out_pc;

  logic       rst2, mem_rd2, mem_rvalid2, redirect2, out_valid2, out_ready2, halted2;
  logic [7:0] mem_addr2, mem_rdata2, redirect_pc2, opcode2, operand1_2, operand2_2, operand3_2, out_pc2;

  cisc_fetch_unit #(.RESET_PC(8'h00), .HALT_OPCODE(8'hFF)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode), .operand1(operand1),
    .operand2(operand2), .operand3(operand3), .out_pc(out_pc), .halted(halted));

  cisc_fetch_unit #(.RESET_PC(8'hFE), .HALT_OPCODE(8'hFF)) dut2 (
    .clk(clk), .rst(rst2), .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_rdata(mem_rdata2),
    .mem_rvalid(mem_rvalid2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .out_valid(out_valid2), .out_ready(out_ready2), .opcode(opcode2), .operand1(operand1_2),
    .operand2(operand2_2), .operand3(operand3_2), .out_pc(out_pc2), .halted(halted2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] mem [256];

  // stimulus controls
  bit         rand_mode = 1'b0;
  bit         spur_en   = 1'b1;
  logic       d_rst = 1'b1, d_redirect = 1'b0, d_ready = 1'b1;
  logic [7:0] d_rpc = 8'h00;
  int         d_lat = 1;
  int         rst_left = 0;

  // memory responder slot (at most one read outstanding)
  bit         resp_active = 1'b0;
  int         resp_due = 0;
  logic [7:0] resp_data = 8'h00;
  bit         got;

  // reference model
  logic [7:0] pc = RST_PC;
  int         nbytes = 0;
  logic [7:0] ibuf [4];
  logic [7:0] ipc = 8'h00;
  bit         pend_valid = 1'b0;
  logic [7:0] pend [4];
  logic [7:0] pend_pc = 8'h00;
  bit         halted_m = 1'b0;
  bit         drain = 1'b0;
  bit         expect_rd = 1'b0;
  bit         after_rst = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle of the main DUT: drive inputs, compare against the model, advance the model.
  task automatic step();
    bit hs, next_rd;
    @(negedge clk);
    cyc++;
    if (rand_mode) begin
      if (rst_left > 0) begin
        rst = 1'b1;
        rst_left--;
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        rst_left = $urandom_range(0, 2);
      end else begin
        rst = 1'b0;
      end
      redirect    = ($urandom_range(0, 29) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 8'hFC + 8'($urandom_range(0, 3))
                                                : 8'($urandom_range(0, 255));
      out_ready   = ($urandom_range(0, 9) < 7);
    end else begin
      rst         = d_rst;
      redirect    = d_redirect;
      redirect_pc = d_rpc;
      out_ready   = d_ready;
    end
    got        = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 8'($urandom_range(0, 255));
    if (resp_active && resp_due == cyc) begin
      mem_rvalid  = 1'b1;
      mem_rdata   = resp_data;
      resp_active = 1'b0;
      got         = 1'b1;
    end else if (!resp_active && spur_en && $urandom_range(0, 7) == 0) begin
      mem_rvalid = 1'b1;
    end
    #1;
    if (after_rst) begin
      chk("rst_opcode", opcode, 8'h00);
      chk("rst_operand1", operand1, 8'h00);
      chk("rst_operand2", operand2, 8'h00);
      chk("rst_operand3", operand3, 8'h00);
      chk("rst_out_pc", out_pc, 8'h00);
      chk("rst_mem_addr", mem_addr, RST_PC);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_halted", halted, 1'b0);
      after_rst = 1'b0;
    end
    if (rst) begin
      chk1("rd_in_reset", mem_rd, 1'b0);
      pc = RST_PC; nbytes = 0; pend_valid = 0; halted_m = 0;
      drain = 0; resp_active = 0; expect_rd = 1; after_rst = 1;
    end else begin
      chk1("out_valid", out_valid, pend_valid);
      if (pend_valid) begin
        chk("opcode", opcode, pend[0]);
        chk("operand1", operand1, pend[1]);
        chk("operand2", operand2, pend[2]);
        chk("operand3", operand3, pend[3]);
        chk("out_pc", out_pc, pend_pc);
      end
      chk1("halted", halted, halted_m);
      if (!redirect) chk1("mem_rd", mem_rd, expect_rd);
      if (mem_rd) chk("mem_addr", mem_addr, pc);
      hs      = pend_valid && out_ready;
      next_rd = 1'b0;
      if (redirect && !hs) begin
        pc = redirect_pc; nbytes = 0; pend_valid = 0; halted_m = 0;
        if (mem_rd || resp_active) drain = 1;
        else begin
          drain   = 0;
          next_rd = 1;
        end
      end else begin
        if (got) begin
          if (drain) begin
            drain   = 0;
            next_rd = 1;
          end else begin
            if (nbytes == 0) ipc = pc;
            ibuf[nbytes] = mem_rdata;
            nbytes++;
            pc++;
            if (nbytes == 4) begin
              nbytes = 0;
              if (ibuf[0] == HALT_OP) halted_m = 1;
              else begin
                pend_valid = 1;
                pend       = ibuf;
                pend_pc    = ipc;
              end
            end else begin
              next_rd = 1;
            end
          end
        end
        if (hs) begin
          pend_valid = 0;
          next_rd    = 1;
        end
      end
      if (mem_rd) begin
        resp_active = 1;
        resp_due    = cyc + (rand_mode ? int'($urandom_range(1, 3)) : d_lat);
        resp_data   = mem[mem_addr];
      end
      expect_rd = next_rd;
    end
  endtask

  task automatic do_reset();
    d_rst = 1'b1;
    step();
    step();
    d_rst = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk1(name, 1'b0, 1'b1);
  endtask

  initial begin
    int seen_at, gap, cnt_valid, rd_after, cnt_got, nrd;
    bit halt_seen, p_rd, seen2;
    logic [7:0] p_addr;
    logic [7:0] rd_log [5];

    rst = 1'b1; redirect = 1'b0; redirect_pc = 8'h00; out_ready = 1'b1;
    mem_rvalid = 1'b0; mem_rdata = 8'h00;
    rst2 = 1'b1; redirect2 = 1'b0; redirect_pc2 = 8'h00; out_ready2 = 1'b1;
    mem_rvalid2 = 1'b0; mem_rdata2 = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    // basic fetch, 1-cycle memory
    mem[0] = 8'h00; mem[1] = 8'h12; mem[2] = 8'h34; mem[3] = 8'h05;
    mem[4] = 8'hA0; mem[5] = 8'hA1; mem[6] = 8'hA2; mem[7] = 8'hA3;
    d_lat = 1; d_ready = 1'b1;
    do_reset();
    seen_at = 99;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid) begin
        seen_at = i;
        break;
      end
    end
    chk_int("basic_latency", seen_at, 8);
    chk("basic_opcode", opcode, 8'h00);
    chk("basic_operand1", operand1, 8'h12);
    chk("basic_operand2", operand2, 8'h34);
    chk("basic_operand3", operand3, 8'h05);
    chk("basic_out_pc", out_pc, 8'h00);
    step();
    chk1("basic_next_rd", mem_rd, 1'b1);
    chk("basic_next_addr", mem_addr, 8'h04);

    // backpressure on the second instruction
    d_ready = 1'b0;
    wait_valid("bp_timeout", 20);
    for (int k = 0; k < 5; k++) begin
      step();
      chk1("bp_valid", out_valid, 1'b1);
      chk("bp_opcode", opcode, 8'hA0);
      chk("bp_operand3", operand3, 8'hA3);
      chk("bp_out_pc", out_pc, 8'h04);
      chk1("bp_no_rd", mem_rd, 1'b0);
    end
    d_ready = 1'b1;
    step();
    chk1("bp_handshake", out_valid, 1'b1);
    step();
    chk1("bp_resume_rd", mem_rd, 1'b1);
    chk("bp_resume_addr", mem_addr, 8'h08);

    // halt at 04 after one valid instruction, then redirect to 00
    mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'h12; mem[3] = 8'h13;
    mem[4] = HALT_OP; mem[5] = 8'h01; mem[6] = 8'h02; mem[7] = 8'h03;
    do_reset();
    cnt_valid = 0; halt_seen = 1'b0; rd_after = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) cnt_valid++;
      if (halted) halt_seen = 1'b1;
      if (halt_seen && mem_rd) rd_after++;
    end
    chk_int("halt_valid_count", cnt_valid, 1);
    chk1("halt_seen", halt_seen, 1'b1);
    chk_int("halt_rd_after", rd_after, 0);
    chk("halt_mem_addr", mem_addr, 8'h08);
    d_redirect = 1'b1; d_rpc = 8'h00;
    step();
    d_redirect = 1'b0;
    step();
    chk1("halt_cleared", halted, 1'b0);
    chk1("halt_restart_rd", mem_rd, 1'b1);
    chk("halt_restart_addr", mem_addr, 8'h00);

    // flush in WAIT with 3-cycle memory
    mem[8'h40] = 8'h55; mem[8'h41] = 8'h66; mem[8'h42] = 8'h77; mem[8'h43] = 8'h88;
    d_lat = 3;
    do_reset();
    step();
    chk1("flush_first_rd", mem_rd, 1'b1);
    d_redirect = 1'b1; d_rpc = 8'h40;
    step();
    d_redirect = 1'b0;
    gap = 99;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (mem_rd) begin
        gap = i;
        break;
      end
    end
    chk_int("flush_gap", gap, 3);
    chk("flush_addr", mem_addr, 8'h40);
    wait_valid("flush_timeout", 40);
    chk("flush_out_pc", out_pc, 8'h40);
    chk("flush_opcode", opcode, 8'h55);
    d_lat = 1;

    // reset after byte 2 is latched
    mem[0] = 8'h21; mem[1] = 8'h22; mem[2] = 8'h23; mem[3] = 8'h24;
    do_reset();
    cnt_got = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (got) cnt_got++;
      if (cnt_got == 3) break;
    end
    chk_int("midrst_bytes", cnt_got, 3);
    chk("midrst_pre_opcode", opcode, 8'h21);
    d_rst = 1'b1;
    step();
    d_rst = 1'b0;
    step();
    chk("midrst_opcode", opcode, 8'h00);
    chk("midrst_operand2", operand2, 8'h00);
    chk("midrst_out_pc", out_pc, 8'h00);
    chk1("midrst_valid", out_valid, 1'b0);
    chk1("midrst_rd", mem_rd, 1'b1);
    chk("midrst_addr", mem_addr, RST_PC);

    // randomized traffic
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) mem[i] = HALT_OP;
    end
    rand_mode = 1'b1;
    rst_left  = 2;
    for (int i = 0; i < 4000; i++) step();
    rand_mode = 1'b0;
    d_rst = 1'b1;
    step();

    // address wrap with RESET_PC = FE on the second instance
    mem[8'hFE] = 8'h31; mem[8'hFF] = 8'h32; mem[8'h00] = 8'h33; mem[8'h01] = 8'h34;
    for (int i = 0; i < 5; i++) rd_log[i] = 8'h5A;
    @(negedge clk);
    @(negedge clk);
    rst2 = 1'b0;
    p_rd = 1'b0; p_addr = 8'h00; nrd = 0; seen2 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      cyc++;
      mem_rvalid2 = p_rd;
      mem_rdata2  = mem[p_addr];
      #1;
      if (mem_rd2) begin
        if (nrd < 5) rd_log[nrd] = mem_addr2;
        nrd++;
      end
      if (out_valid2 && !seen2) begin
        seen2 = 1'b1;
        chk("wrap_out_pc", out_pc2, 8'hFE);
        chk("wrap_opcode", opcode2, 8'h31);
        chk("wrap_operand3", operand3_2, 8'h34);
      end
      p_rd   = mem_rd2;
      p_addr = mem_addr2;
    end
    chk1("wrap_seen", seen2, 1'b1);
    chk("wrap_rd0", rd_log[0], 8'hFE);
    chk("wrap_rd1", rd_log[1], 8'hFF);
    chk("wrap_rd2", rd_log[2], 8'h00);
    chk("wrap_rd3", rd_log[3], 8'h01);
    chk("wrap_rd4", rd_log[4], 8'h02);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
